// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared widths and loader state encoding for the FIR block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 8;
  localparam int CKSUM_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_FINISH = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/fir_cksum_acc.sv
// ============================================================================
// Module   : fir_cksum_acc
// Brief    : Wrapping checksum accumulator of zero-extended input words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_cksum_acc
  import fir_pkg::*;
#(
  parameter int DIN_W = DATA_W
) (
  input  logic               Clk,
  input  logic               Hlt,
  input  logic               clr,
  input  logic               en,
  input  logic [DIN_W-1:0]   din,
  output logic [CKSUM_W-1:0] sum
);

  logic [CKSUM_W-1:0] sum_q;
  logic [CKSUM_W-1:0] sum_d;

  // Clear takes priority so a new load never inherits a stale partial sum.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + CKSUM_W'(din);
    end
  end

  always_ff @(posedge Clk) begin
    if (Hlt) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

`default_nettype wire

// File: rtl/fir_coeff_loader.sv
// ============================================================================
// Module   : fir_coeff_loader
// Brief    : Streams taps into the FIR coefficient memory, then reads them
//            back and compares checksums while holding the filter halted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int NUM_TAPS     = 32,
  parameter int DATA_W       = fir_pkg::DATA_W,
  parameter int ADDR_W       = fir_pkg::ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Hlt,
  input  logic              start,
  input  logic              coef_valid,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_ready,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_value,
  output logic              load,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_value,
  output logic              fir_hlt,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);
  localparam int                SR_W     = READ_LATENCY + 1;

  loader_state_t state_q, state_d;

  logic [ADDR_W-1:0]  wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [ADDR_W-1:0]  write_address_q, write_address_d;
  logic [DATA_W-1:0]  write_value_q, write_value_d;
  logic [ADDR_W-1:0]  read_address_q, read_address_d;
  logic               load_q, load_d;
  logic               error_q, error_d;
  logic               issue_done_q, issue_done_d;
  logic [SR_W-1:0]    cap_sr_q, cap_sr_d;
  logic               addr_vld;
  logic               handshake;
  logic               capture;
  logic               sums_clr;
  logic [CKSUM_W-1:0] wr_sum;
  logic [CKSUM_W-1:0] rd_sum;

  assign handshake = coef_valid && coef_ready;
  // Bit 0 marks an address on the bus this cycle; bit READ_LATENCY marks its data.
  assign capture   = cap_sr_q[READ_LATENCY];

  always_comb begin
    state_d         = state_q;
    wr_idx_d        = wr_idx_q;
    rd_idx_d        = rd_idx_q;
    cap_cnt_d       = cap_cnt_q;
    write_address_d = write_address_q;
    write_value_d   = write_value_q;
    read_address_d  = read_address_q;
    load_d          = 1'b0;
    error_d         = error_q;
    issue_done_d    = issue_done_q;
    addr_vld        = 1'b0;
    sums_clr        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d      = 1'b0;
          wr_idx_d     = '0;
          rd_idx_d     = '0;
          cap_cnt_d    = '0;
          issue_done_d = 1'b0;
          sums_clr     = 1'b1;
          state_d      = S_WRITE;
        end
      end

      S_WRITE: begin
        if (handshake) begin
          write_address_d = wr_idx_q;
          write_value_d   = coef_data;
          load_d          = 1'b1;
          wr_idx_d        = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d = S_VERIFY;
          end
        end
      end

      S_VERIFY: begin
        if (!issue_done_q) begin
          read_address_d = rd_idx_q;
          addr_vld       = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            issue_done_d = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
        if (capture) begin
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_q == LAST_IDX) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        error_d = (wr_sum != rd_sum);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    cap_sr_d = SR_W'({cap_sr_q, addr_vld});
  end

  always_ff @(posedge Clk) begin
    if (Hlt) begin
      state_q         <= S_IDLE;
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      cap_cnt_q       <= '0;
      write_address_q <= '0;
      write_value_q   <= '0;
      read_address_q  <= '0;
      load_q          <= 1'b0;
      error_q         <= 1'b0;
      issue_done_q    <= 1'b0;
      cap_sr_q        <= '0;
    end else begin
      state_q         <= state_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      cap_cnt_q       <= cap_cnt_d;
      write_address_q <= write_address_d;
      write_value_q   <= write_value_d;
      read_address_q  <= read_address_d;
      load_q          <= load_d;
      error_q         <= error_d;
      issue_done_q    <= issue_done_d;
      cap_sr_q        <= cap_sr_d;
    end
  end

  fir_cksum_acc #(
    .DIN_W (DATA_W)
  ) u_wr_sum (
    .Clk (Clk),
    .Hlt (Hlt),
    .clr (sums_clr),
    .en  (handshake),
    .din (coef_data),
    .sum (wr_sum)
  );

  fir_cksum_acc #(
    .DIN_W (DATA_W)
  ) u_rd_sum (
    .Clk (Clk),
    .Hlt (Hlt),
    .clr (sums_clr),
    .en  (capture),
    .din (read_value),
    .sum (rd_sum)
  );

  assign coef_ready    = (state_q == S_WRITE);
  assign busy          = (state_q != S_IDLE);
  assign fir_hlt       = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign write_address = write_address_q;
  assign write_value   = write_value_q;
  assign read_address  = read_address_q;
  assign load          = load_q;
  assign error         = error_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
// ============================================================================
// Module   : tb_fir_coeff_loader
// Brief    : Self-checking bench with behavioural FIR memory and write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_coeff_loader;

  localparam int N  = 4;
  localparam int NW = 32;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Hlt, start, coef_valid;
  logic [11:0] coef_data, read_value, write_value;
  logic        coef_ready, load, fir_hlt, busy, done, error;
  logic [7:0]  write_address, read_address;

  logic        start_w, coef_valid_w;
  logic [11:0] coef_data_w, read_value_w, write_value_w;
  logic        coef_ready_w, load_w, fir_hlt_w, busy_w, done_w, error_w;
  logic [7:0]  write_address_w, read_address_w;

  fir_coeff_loader #(.NUM_TAPS(N), .READ_LATENCY(1)) dut (
    .Clk(Clk), .Hlt(Hlt), .start(start), .coef_valid(coef_valid),
    .coef_data(coef_data), .coef_ready(coef_ready),
    .write_address(write_address), .write_value(write_value), .load(load),
    .read_address(read_address), .read_value(read_value),
    .fir_hlt(fir_hlt), .busy(busy), .done(done), .error(error)
  );

  fir_coeff_loader #(.NUM_TAPS(NW), .READ_LATENCY(1)) dut_w (
    .Clk(Clk), .Hlt(Hlt), .start(start_w), .coef_valid(coef_valid_w),
    .coef_data(coef_data_w), .coef_ready(coef_ready_w),
    .write_address(write_address_w), .write_value(write_value_w), .load(load_w),
    .read_address(read_address_w), .read_value(read_value_w),
    .fir_hlt(fir_hlt_w), .busy(busy_w), .done(done_w), .error(error_w)
  );

  // FIR coefficient memories: synchronous write, one-cycle registered readback.
  logic [11:0] mem   [0:255];
  logic [11:0] mem_w [0:255];
  logic        corrupt;

  always @(posedge Clk) begin
    if (load) mem[write_address] <= write_value;
    read_value <= mem[read_address] ^ {11'd0, corrupt && (read_address == 8'd2)};
    if (load_w) mem_w[write_address_w] <= write_value_w;
    read_value_w <= mem_w[read_address_w];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [7:0]  addr;
    logic [11:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   sb_idx    = 0;
  int   load_cnt  = 0;
  int   done_cnt  = 0;
  int   done_cyc  = 0;
  bit   hs_prev   = 1'b0;

  always @(negedge Clk) begin
    exp_t e;
    chk("load_follows_handshake", load, hs_prev);
    if (load) begin
      load_cnt++;
      if (sbq.size() == 0) begin
        chk("load_without_pending_handshake", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("write_address", write_address, e.addr);
        chk("write_value", write_value, e.val);
        chk("load_latency", cyc, e.cyc + 1);
      end
    end
    hs_prev = coef_valid && coef_ready && !Hlt;
    if (hs_prev) begin
      sbq.push_back('{addr: sb_idx[7:0], val: coef_data, cyc: cyc});
      sb_idx++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    logic [3:0][11:0] c;
    bit               stall;
    bit               corrupt;
    bit               exp_err;
    bit               poke;
  } vec_t;

  function automatic vec_t mk(input logic [11:0] c0, c1, c2, c3,
                              input bit stall, input bit cor, input bit err, input bit poke);
    vec_t v;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.stall = stall; v.corrupt = cor; v.exp_err = err; v.poke = poke;
    return v;
  endfunction

  logic [6:0] stall_pat = 7'b1011001;

  task automatic run_case(input vec_t v, input int id);
    int i, t, n0, d0;
    corrupt  = v.corrupt;
    sb_idx   = 0;
    load_cnt = 0;
    d0       = done_cnt;
    @(posedge Clk); #1;
    start = 1'b1;
    n0    = cyc;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_fir_hlt", fir_hlt, 1);
    chk("start_coef_ready", coef_ready, 1);
    chk("start_clears_error", error, 0);
    i = 0;
    t = 0;
    while (i < N && t < 50) begin
      coef_valid = (!v.stall || t > 6) ? 1'b1 : stall_pat[t];
      coef_data  = v.c[i];
      if (coef_valid && coef_ready) i++;
      @(posedge Clk); #1;
      t++;
    end
    coef_valid = 1'b0;
    chk("write_phase_cycles", t, v.stall ? 7 : 4);
    chk("verify_ready_low", coef_ready, 0);
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      start = v.poke && (cyc == n0 + 7);
      @(posedge Clk); #1;
      t++;
    end
    start = 1'b0;
    chk("done_seen", (done_cnt != d0), 1);
    chk("done_latency", done_cyc - n0, v.stall ? 14 : 11);
    chk("error_after_done", error, v.exp_err);
    chk("idle_busy", busy, 0);
    chk("idle_fir_hlt", fir_hlt, 0);
    chk("loads_per_case", load_cnt, N);
    chk("scoreboard_drained", sbq.size(), 0);
    for (int k = 0; k < N; k++) chk("memory_content", mem[k], v.c[k]);
    repeat (4) @(posedge Clk);
    #1;
    chk("single_done", done_cnt - d0, 1);
    chk("error_sticky", error, v.exp_err);
    chk("no_restart", busy, 0);
    if (errors != 0) $display("case %0d finished with %0d errors so far", id, errors);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, k, n0, d0;
    vecs[0] = mk(12'd1,    12'd2,    12'd3,    12'd4095, 0, 0, 0, 0);
    vecs[1] = mk(12'd5,    12'd6,    12'd7,    12'd8,    1, 0, 0, 0);
    vecs[2] = mk(12'd10,   12'd20,   12'd30,   12'd40,   0, 1, 1, 0);
    vecs[3] = mk(12'd0,    12'd0,    12'd0,    12'd0,    0, 0, 0, 0);
    vecs[4] = mk(12'd100,  12'd200,  12'd300,  12'd400,  0, 0, 0, 1);
    vecs[5] = mk(12'd4095, 12'd4095, 12'd4095, 12'd4095, 1, 1, 1, 0);

    Hlt = 1'b1; start = 1'b0; coef_valid = 1'b0; coef_data = '0; corrupt = 1'b0;
    start_w = 1'b0; coef_valid_w = 1'b0; coef_data_w = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fir_hlt", fir_hlt, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_write_address", write_address, 0);
    chk("rst_write_value", write_value, 0);
    chk("rst_read_address", read_address, 0);
    chk("rst_busy_w", busy_w, 0);
    // start coincident with reset must be ignored
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    Hlt   = 1'b0;
    chk("start_during_hlt_ignored", busy, 0);
    @(posedge Clk); #1;
    chk("still_idle", busy, 0);

    for (int v = 0; v < 6; v++) run_case(vecs[v], v);

    // Mid-load reset after two accepted coefficients
    d0 = done_cnt;
    sb_idx = 0;
    corrupt = 1'b0;
    @(posedge Clk); #1;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    coef_valid = 1'b1;
    coef_data  = 12'd111;
    @(posedge Clk); #1;
    coef_data  = 12'd222;
    @(posedge Clk); #1;
    coef_valid = 1'b0;
    Hlt = 1'b1;
    @(posedge Clk); #1;
    Hlt = 1'b0;
    chk("hlt_busy", busy, 0);
    chk("hlt_fir_hlt", fir_hlt, 0);
    chk("hlt_load", load, 0);
    chk("hlt_coef_ready", coef_ready, 0);
    chk("hlt_error", error, 0);
    chk("hlt_write_address", write_address, 0);
    repeat (20) @(posedge Clk);
    #1;
    chk("hlt_no_done", done_cnt - d0, 0);
    chk("hlt_scoreboard_empty", sbq.size(), 0);
    run_case(vecs[0], 6);

    // Checksum wrap on the 32-tap instance
    @(posedge Clk); #1;
    start_w = 1'b1;
    n0 = cyc;
    @(posedge Clk); #1;
    start_w = 1'b0;
    coef_valid_w = 1'b1;
    coef_data_w  = 12'hFFF;
    k = 0;
    t = 0;
    while (k < NW && t < 80) begin
      if (coef_valid_w && coef_ready_w) k++;
      @(posedge Clk); #1;
      t++;
    end
    coef_valid_w = 1'b0;
    chk("wrap_write_cycles", t, NW);
    t = 0;
    while (!done_w && t < 200) begin
      @(posedge Clk); #1;
      t++;
    end
    chk("wrap_done_seen", done_w, 1);
    chk("wrap_done_latency", cyc - n0, 1 + NW + NW + 1 + 1);
    @(posedge Clk); #1;
    chk("wrap_error", error_w, 0);
    chk("wrap_busy", busy_w, 0);
    chk("wrap_mem_first", mem_w[0], 12'hFFF);
    chk("wrap_mem_last", mem_w[NW-1], 12'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient-load front end for `fir_transpose`. Accepts a stream of 12-bit tap coefficients over a valid/ready handshake and writes them sequentially into the filter's coefficient memory through its `write_address`/`write_value`/`load` port. It then reads every tap back through `read_address`/`read_value`, compares checksums, and reports done or error. It holds the filter halted for the whole operation.

## Interface
Parameters:
- `NUM_TAPS`, 32: coefficients per load; range 1..256.
- `DATA_W`, 12: coefficient width; must match the FIR.
- `ADDR_W`, 8: coefficient address width; must match the FIR.
- `READ_LATENCY`, 1: cycles from `read_address` to valid `read_value`; range 0..3.

Ports:
- `Clk`  in  1  single clock; all logic on rising edge.
- `Hlt`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; ignored unless in IDLE.
- `coef_valid`  in  1  upstream coefficient valid.
- `coef_data`  in  DATA_W  coefficient value, raw bits.
- `coef_ready`  out  1  loader accepts `coef_data` this cycle.
- `write_address`  out  ADDR_W  to FIR coefficient memory.
- `write_value`  out  DATA_W  to FIR coefficient memory.
- `load`  out  1  FIR coefficient write enable.
- `read_address`  out  ADDR_W  to FIR readback port.
- `read_value`  in  DATA_W  from FIR readback port.
- `fir_hlt`  out  1  halt request; top level ORs it with `Hlt` into the FIR's `Hlt`.
- `busy`  out  1  load or verify in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  checksum mismatch; sticky until the next accepted `start`.

## Operation
- States: IDLE, WRITE, VERIFY, FINISH.
- IDLE:
  - `coef_ready`=0.
  - On `start`: clear `error`, write index, read index and both checksums, then go to WRITE.
- WRITE:
  - `coef_ready`=1.
  - Each handshake (`coef_valid`&&`coef_ready`) registers `write_address`=idx, `write_value`=`coef_data` and `load`=1 for one cycle.
  - The same handshake adds `coef_data` (zero-extended) to `wr_sum`, and idx increments.
  - The handshake with idx==NUM_TAPS-1 goes to VERIFY; `coef_ready` drops in that same transition.
  - Cycles without a handshake: `load`=0; address and value hold.
- VERIFY:
  - `read_address` steps 0..NUM_TAPS-1, one per cycle.
  - `read_value` is captured READ_LATENCY cycles after each address and added to `rd_sum`.
  - After the NUM_TAPS-th capture, go to FINISH.
- FINISH (one cycle):
  - `error`<=(`wr_sum`!=`rd_sum`).
  - `done`=1.
  - Next state IDLE.
- Checksums are 16-bit unsigned with wrap-around: sum of zero-extended 12-bit values, modulo 2^16.
- `busy`=`fir_hlt`=1 in WRITE, VERIFY and FINISH; both are 0 in IDLE.
- `start` outside IDLE is ignored.
- `coef_valid` outside WRITE is ignored; data is not consumed.
- Addresses never exceed NUM_TAPS-1, so there is no address wrap.

## Timing
- Reset values:
  - `coef_ready`, `load`, `busy`, `fir_hlt`, `done`, `error` = 0.
  - `write_address`, `write_value`, `read_address` = 0.
  - State = IDLE.
- `start` at cycle n: state is WRITE at n+1, and `coef_ready`, `busy` and `fir_hlt` are high from n+1.
- Write latency: a handshake in cycle k produces `load`=1 and the matching address/value in cycle k+1.
- With back-to-back valid, one coefficient is written per cycle.
- Minimum total duration, from `start` to the `done` pulse: 1 + NUM_TAPS (write) + NUM_TAPS + READ_LATENCY (verify) + 1 (finish) cycles.
- The last `load` pulse coincides with the first VERIFY cycle. The FIR memory must accept a write and a read of a different address in the same cycle.
- `Hlt` asserted mid-operation:
  - All outputs return to reset values on the next edge.
  - The partial load is abandoned and `error` is not set.
  - Upstream must restart the stream from tap 0.
- `start` coincident with `Hlt`: `Hlt` wins.

## Structure
- Shared package `fir_pkg` holds:
  - `DATA_W`, `ADDR_W`, `CKSUM_W`=16.
  - The state enum `loader_state_t`.
  - The shared package also serves `fir_transpose`.
- One sub-module, `fir_cksum_acc`:
  - Ports: `Clk`, `Hlt`, `clr`, `en`, `din`, `sum`.
  - 16-bit wrapping accumulator, instantiated twice (write sum, read sum).
- The READ_LATENCY capture-valid shift register stays in the top module.

## Test plan
All scenarios use NUM_TAPS=4 and READ_LATENCY=1, with a behavioural FIR memory model.
- **Clean load:** `start`, then coefficients 1, 2, 3, 4095 back-to-back. Expect:
  - `load` pulses at addresses 0..3.
  - `done` exactly 11 cycles after `start`.
  - `error`=0 and memory = {1,2,3,4095}.
- **Stalled upstream:** `coef_valid` toggles 1,0,0,1,…
  - `load` is high only in cycles following a handshake.
  - Addresses remain 0..3 in order, with no duplicates.
  - Total write phase is 7 cycles.
- **Corrupted readback:** the model flips bit 0 at address 2. Expect `done` with `error`=1, held until the next `start`.
- **Checksum wrap:** NUM_TAPS=32, all coefficients 4095 (sum 131040 mod 65536 = 65504). Expect `error`=0.
- **Mid-load reset:** `Hlt` asserted after 2 accepted coefficients.
  - Next cycle: `busy`=`fir_hlt`=`load`=0 and `done` never pulses.
  - A subsequent full load succeeds.
- **Ignored start:** `start` pulsed during VERIFY. Expect no restart; single `done` at the nominal cycle.
